// File: rtl/asrv32_dmem_responder_pkg.sv
// Shared encodings for the asrv32 data-memory responder: access sizes, FSM states,
// the latched request record and the legal store-mask rule.
package asrv32_dmem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [3:0] legal_store_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SIZE_BYTE: m = 4'b0001 << lane;
            SIZE_HALF: m = 4'b0011 << {lane[1], 1'b0};
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/asrv32_bytemask_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a registered read port.
// The read register only updates on i_re, so it doubles as the load-data holding register.
module asrv32_bytemask_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          i_clk,
    input  logic [3:0]    i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                mem_q[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            rdata_q <= mem_q[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/asrv32_dmem_responder.sv
// Load/store slave for the asrv32 memory stage: one request at a time, WAIT_STATES
// wait cycles, byte-masked stores, right-aligned zero-filled load data.
//
// state     | meaning
// DMEM_IDLE | waiting for i_req; request fields taken straight from the inputs
// DMEM_WAIT | counting down wait states on the latched request
// DMEM_RESP | o_ack (and o_err) pulse for one cycle
module asrv32_dmem_responder
    import asrv32_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wr_mask,
    input  logic [31:0] i_store_data,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_data_from_memory,
    output logic        o_busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_e state_q, state_d;
    dmem_req_t   req_q, req_d, cur;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d, err_q, err_d, busy_q, busy_d, zero_q, zero_d;
    logic [1:0]  fmt_size_q, fmt_size_d, fmt_off_q, fmt_off_d;
    logic        go_resp, fault, addr_oob, misalign, mask_bad;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata, lane_shifted;

    // With zero wait states the RAM access happens on the accepting edge, so it must see the live inputs.
    always_comb begin
        if (state_q == DMEM_IDLE) begin
            cur = '{wr: i_wr_en, addr: i_addr, size: i_size, mask: i_wr_mask, wdata: i_store_data};
        end else begin
            cur = req_q;
        end
    end

    always_comb begin
        addr_oob = (cur.addr >> (AW + 2)) != 32'd0;
        misalign = ((cur.size == SIZE_HALF) && cur.addr[0]) ||
                   ((cur.size == SIZE_WORD) && (cur.addr[1:0] != 2'b00));
        mask_bad = cur.wr && (cur.mask != legal_store_mask(cur.size, cur.addr[1:0]));
        fault    = addr_oob || (cur.size == SIZE_ILL) || misalign || mask_bad;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        go_resp    = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        zero_d     = zero_q;
        fmt_size_d = fmt_size_q;
        fmt_off_d  = fmt_off_q;
        case (state_q)
            DMEM_IDLE: begin
                if (i_req) begin
                    req_d = cur;
                    if (WAIT_STATES == 0) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == 4'd0) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
        if (go_resp) begin
            state_d = DMEM_RESP;
            ack_d   = 1'b1;
            err_d   = fault;
            if (fault) begin
                zero_d = 1'b1;
            end else if (!cur.wr) begin
                zero_d     = 1'b0;
                fmt_size_d = cur.size;
                fmt_off_d  = cur.addr[1:0];
            end
        end
        busy_d = (state_d != DMEM_IDLE);
    end

    // Gated by reset so an edge that both resets and would enter RESP commits nothing.
    assign ram_we = (go_resp && cur.wr && !fault && i_rst_n) ? cur.mask : 4'b0000;
    assign ram_re = go_resp && !cur.wr && !fault && i_rst_n;

    asrv32_bytemask_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_re    (ram_re),
        .i_addr  (cur.addr[AW+1:2]),
        .i_wdata (cur.wdata),
        .o_rdata (ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= DMEM_IDLE;
            req_q      <= '0;
            cnt_q      <= 4'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            zero_q     <= 1'b1;
            fmt_size_q <= SIZE_WORD;
            fmt_off_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            zero_q     <= zero_d;
            fmt_size_q <= fmt_size_d;
            fmt_off_q  <= fmt_off_d;
        end
    end

    always_comb begin
        lane_shifted = ram_rdata >> {fmt_off_q, 3'b000};
        case (fmt_size_q)
            SIZE_BYTE: o_data_from_memory = {24'd0, lane_shifted[7:0]};
            SIZE_HALF: o_data_from_memory = {16'd0, lane_shifted[15:0]};
            default:   o_data_from_memory = ram_rdata;
        endcase
        if (zero_q) begin
            o_data_from_memory = 32'd0;
        end
    end

    assign o_ack  = ack_q;
    assign o_err  = err_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_asrv32_dmem_responder.sv
// Bench for asrv32_dmem_responder: one instance with one wait state, one with none,
// driven by a vector table, random traffic against a word-array model, and hand sequences.
module tb_asrv32_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [1:0]  size  [2];
    logic [3:0]  mask  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] rdata [2];
    logic        busy  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mmem  [2][1024];
    logic [31:0] mdata [2];

    asrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_req(req[0]), .i_wr_en(wr[0]), .i_addr(addr[0]),
        .i_size(size[0]), .i_wr_mask(mask[0]), .i_store_data(wdata[0]), .o_ack(ack[0]),
        .o_err(err[0]), .o_data_from_memory(rdata[0]), .o_busy(busy[0]));

    asrv32_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_req(req[1]), .i_wr_en(wr[1]), .i_addr(addr[1]),
        .i_size(size[1]), .i_wr_mask(mask[1]), .i_store_data(wdata[1]), .o_ack(ack[1]),
        .o_err(err[1]), .o_data_from_memory(rdata[1]), .o_busy(busy[1]));

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [1:0]  s;
        logic [3:0]  m;
        logic [31:0] wd;
        logic        e;
        logic [31:0] q;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic [3:0] m, input logic [31:0] wd);
        req[d] = r; wr[d] = w; addr[d] = a; size[d] = s; mask[d] = m; wdata[d] = wd;
    endtask

    function automatic logic [3:0] spec_mask(input logic [1:0] s, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (s == 2'd0) return 4'(1 << lane);
        if (s == 2'd1) return 4'(3 << (lane - (lane % 2)));
        return 4'hF;
    endfunction

    task automatic model(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic [3:0] m, input logic [31:0] wd,
                         output logic me, output logic [31:0] md);
        int idx;
        int lane;
        logic [31:0] word;
        me = 1'b0;
        if (a >= 32'd4096) me = 1'b1;
        if (s == 2'd3) me = 1'b1;
        if (s == 2'd1 && (a % 2) != 0) me = 1'b1;
        if (s == 2'd2 && (a % 4) != 0) me = 1'b1;
        if (w && m != spec_mask(s, a)) me = 1'b1;
        if (me) begin
            mdata[d] = 32'd0;
        end else begin
            idx  = int'(a / 4);
            lane = int'(a % 4);
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) mmem[d][idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                word = mmem[d][idx] >> (8 * lane);
                if (s == 2'd0) word = word & 32'h0000_00FF;
                else if (s == 2'd1) word = word & 32'h0000_FFFF;
                mdata[d] = word;
            end
        end
        md = mdata[d];
    endtask

    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [3:0] m, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] q);
        lat = -1;
        e   = 1'b0;
        q   = 32'd0;
        @(negedge clk);
        drive(d, 1'b1, w, a, s, m, wd);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_after_accept", 32'(busy[d]), 32'd1);
            if (ack[d]) begin
                lat = c;
                e   = err[d];
                q   = rdata[d];
                break;
            end
            // scrambled inputs after acceptance must be ignored
            drive(d, 1'b1, 1'($urandom), $urandom, 2'($urandom), 4'($urandom), $urandom);
        end
        drive(d, 1'b0, 1'b0, 32'd0, 2'd0, 4'd0, 32'd0);
        if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [3:0] m, input logic [31:0] wd,
                       output logic e, output logic [31:0] q);
        int lat;
        logic me;
        logic [31:0] md;
        xact(d, w, a, s, m, wd, lat, e, q);
        model(d, w, a, s, m, wd, me, md);
        chk($sformatf("lat d%0d a=%h", d, a), 32'(lat), (d == 0) ? 32'd2 : 32'd1);
        chk($sformatf("err d%0d a=%h s=%0d w=%0b", d, a, s, w), 32'(e), 32'(me));
        chk($sformatf("data d%0d a=%h s=%0d w=%0b", d, a, s, w), q, md);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic        e;
        logic [31:0] q;
        logic [31:0] a;
        logic [1:0]  s;
        logic [3:0]  m;
        logic        w;

        tbl[0]  = '{1'b1, 32'h000,  2'd2, 4'hF,    32'h1111_1111, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b1, 32'h010,  2'd2, 4'hF,    32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[2]  = '{1'b1, 32'h014,  2'd2, 4'hF,    32'h2222_2222, 1'b0, 32'h0000_0000};
        tbl[3]  = '{1'b0, 32'h010,  2'd2, 4'h0,    32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 32'h012,  2'd0, 4'b0100, 32'h00AA_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 32'h010,  2'd2, 4'h0,    32'h0,         1'b0, 32'hDEAA_BEEF};
        tbl[6]  = '{1'b0, 32'h012,  2'd0, 4'h0,    32'h0,         1'b0, 32'h0000_00AA};
        tbl[7]  = '{1'b0, 32'h012,  2'd1, 4'h0,    32'h0,         1'b0, 32'h0000_DEAA};
        tbl[8]  = '{1'b0, 32'h011,  2'd1, 4'h0,    32'h0,         1'b1, 32'h0000_0000};
        tbl[9]  = '{1'b0, 32'h010,  2'd2, 4'h0,    32'h0,         1'b0, 32'hDEAA_BEEF};
        tbl[10] = '{1'b1, 32'h1000, 2'd2, 4'hF,    32'h1234_5678, 1'b1, 32'h0000_0000};
        tbl[11] = '{1'b0, 32'h000,  2'd2, 4'h0,    32'h0,         1'b0, 32'h1111_1111};
        tbl[12] = '{1'b1, 32'h014,  2'd1, 4'b0001, 32'h0000_00FF, 1'b1, 32'h0000_0000};
        tbl[13] = '{1'b0, 32'h014,  2'd2, 4'h0,    32'h0,         1'b0, 32'h2222_2222};
        tbl[14] = '{1'b0, 32'h018,  2'd3, 4'h0,    32'h0,         1'b1, 32'h0000_0000};
        tbl[15] = '{1'b0, 32'h012,  2'd2, 4'h0,    32'h0,         1'b1, 32'h0000_0000};
        tbl[16] = '{1'b0, 32'h013,  2'd0, 4'h0,    32'h0,         1'b0, 32'h0000_00DE};
        tbl[17] = '{1'b1, 32'h016,  2'd1, 4'b1100, 32'h5566_0000, 1'b0, 32'h0000_00DE};
        tbl[18] = '{1'b0, 32'h014,  2'd2, 4'h0,    32'h0,         1'b0, 32'h5566_2222};
        tbl[19] = '{1'b0, 32'h016,  2'd1, 4'h0,    32'h0,         1'b0, 32'h0000_5566};
        tbl[20] = '{1'b1, 32'h010,  2'd0, 4'b0011, 32'h0000_FFFF, 1'b1, 32'h0000_0000};
        tbl[21] = '{1'b0, 32'h010,  2'd2, 4'h0,    32'h0,         1'b0, 32'hDEAA_BEEF};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 32'd0, 2'd0, 4'd0, 32'd0);
            mdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ack d%0d", d),  32'(ack[d]),  32'd0);
            chk($sformatf("reset err d%0d", d),  32'(err[d]),  32'd0);
            chk($sformatf("reset busy d%0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("reset data d%0d", d), rdata[d],     32'd0);
            rst_n[d] = 1'b1;
        end

        for (int i = 0; i < 22; i++) begin
            run(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].m, tbl[i].wd, e, q);
            chk($sformatf("tbl[%0d] err", i), 32'(e), 32'(tbl[i].e));
            chk($sformatf("tbl[%0d] data", i), q, tbl[i].q);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                run(d, 1'b1, 32'(4 * i), 2'd2, 4'hF, $urandom, e, q);
            end
        end

        for (int i = 0; i < 210; i++) begin
            int d;
            d = (i < 150) ? 0 : 1;
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_1000) : 32'($urandom_range(0, 63));
            s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : spec_mask(s, a);
            run(d, w, a, s, m, $urandom, e, q);
        end

        // zero wait states, i_req held high across a store and the following load
        begin
            logic me;
            logic [31:0] md;
            @(negedge clk);
            drive(1, 1'b1, 1'b1, 32'h20, 2'd2, 4'hF, 32'hCAFE_F00D);
            model(1, 1'b1, 32'h20, 2'd2, 4'hF, 32'hCAFE_F00D, me, md);
            @(negedge clk);
            chk("b2b ack c1", 32'(ack[1]), 32'd1);
            chk("b2b err c1", 32'(err[1]), 32'd0);
            drive(1, 1'b1, 1'b0, 32'h20, 2'd2, 4'h0, 32'd0);
            @(negedge clk);
            chk("b2b ack c2", 32'(ack[1]), 32'd0);
            chk("b2b busy c2", 32'(busy[1]), 32'd0);
            @(negedge clk);
            chk("b2b ack c3", 32'(ack[1]), 32'd1);
            chk("b2b data c3", rdata[1], 32'hCAFE_F00D);
            model(1, 1'b0, 32'h20, 2'd2, 4'h0, 32'd0, me, md);
            drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 4'd0, 32'd0);
            @(negedge clk);
            chk("b2b ack c4", 32'(ack[1]), 32'd0);
        end

        // reset during the WAIT cycle of a store
        run(0, 1'b0, 32'h10, 2'd2, 4'h0, 32'd0, e, q);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h30, 2'd2, 4'hF, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("rst busy in wait", 32'(busy[0]), 32'd1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("rst ack", 32'(ack[0]), 32'd0);
        chk("rst err", 32'(err[0]), 32'd0);
        chk("rst busy", 32'(busy[0]), 32'd0);
        chk("rst data", rdata[0], 32'd0);
        rst_n[0] = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 4'd0, 32'd0);
        mdata[0] = 32'd0;
        @(negedge clk);
        chk("rst no late ack", 32'(ack[0]), 32'd0);
        run(0, 1'b0, 32'h30, 2'd2, 4'h0, 32'd0, e, q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
